// File: rtl/shift_cmd_queue.sv
`default_nettype none
// ============================================================================
//  Module   : shift_cmd_queue
//  Purpose  : FIFO of shift commands {direction, amount, data} feeding a
//             one-cycle registered barrel shifter. Commands are accepted with
//             an In_Valid/In_Ready handshake and issued to the shifter when
//             Out_Enable is high. There is no bypass, so a command issues no
//             earlier than the edge after it is accepted. Result_Valid follows
//             Issue_Valid by one cycle to track the shifter latency.
//  Ports    : Clock, Reset (async, active-high)
//             In_Valid, In_Ready, In_Direction, In_Shift_Amount, In_Data
//                                      - upstream command handshake
//             Out_Enable               - downstream may take a command
//             Direction, Shift_Amount, Data_In, Issue_Valid
//                                      - registered command to the shifter
//             Result_Valid             - shifter output is valid
//             Count                    - current occupancy
//             Drop_Err                 - sticky: command offered while full
//  Params   : DEPTH - queue depth, one of 2, 4 or 8
//  Revision : 1.0 - initial release
// ============================================================================
module shift_cmd_queue #(
   parameter int DEPTH = 4
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic                     In_Valid,
   output logic                     In_Ready,
   input  logic                     In_Direction,
   input  logic [2:0]               In_Shift_Amount,
   input  logic [7:0]               In_Data,
   input  logic                     Out_Enable,
   output logic                     Direction,
   output logic [2:0]               Shift_Amount,
   output logic [7:0]               Data_In,
   output logic                     Issue_Valid,
   output logic                     Result_Valid,
   output logic [$clog2(DEPTH):0]   Count,
   output logic                     Drop_Err
);

   localparam int              c_AW    = $clog2(DEPTH);
   localparam logic [c_AW:0]   c_DEPTH = (c_AW + 1)'(DEPTH);

   // Storage: entry layout is {direction, amount[2:0], data[7:0]}
   logic [11:0]      r_mem [DEPTH];
   logic [c_AW-1:0]  r_wr_ptr;
   logic [c_AW-1:0]  r_rd_ptr;
   logic [c_AW:0]    r_count;

   logic             r_direction;
   logic [2:0]       r_shift_amount;
   logic [7:0]       r_data_in;
   logic             r_issue_valid;
   logic             r_result_valid;
   logic             r_drop_err;

   logic             w_not_full;
   logic             w_push;
   logic             w_pop;
   logic             w_drop;
   logic [11:0]      w_head;

   // Readiness comes from the occupancy register only; Out_Enable never
   // feeds it, so a full queue stays not-ready even on a popping cycle.
   assign w_not_full = (r_count < c_DEPTH);
   assign w_push     = In_Valid && w_not_full;
   assign w_pop      = Out_Enable && (r_count != '0);
   assign w_drop     = In_Valid && !w_not_full;
   assign w_head     = r_mem[r_rd_ptr];

   // Storage is not reset: stale entries are unreachable once the pointers
   // and count are cleared.
   always_ff @(posedge Clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {In_Direction, In_Shift_Amount, In_Data};
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
         r_direction    <= 1'b0;
         r_shift_amount <= 3'd0;
         r_data_in      <= 8'd0;
         r_issue_valid  <= 1'b0;
         r_result_valid <= 1'b0;
         r_drop_err     <= 1'b0;
      end else begin
         // DEPTH is a power of two, so pointers wrap naturally.
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            {r_direction, r_shift_amount, r_data_in} <= w_head;
         end
         r_issue_valid  <= w_pop;
         r_result_valid <= r_issue_valid;

         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase

         if (w_drop) begin
            r_drop_err <= 1'b1;
         end
      end
   end

   // In_Ready is forced low while Reset is asserted.
   assign In_Ready     = w_not_full && !Reset;
   assign Direction    = r_direction;
   assign Shift_Amount = r_shift_amount;
   assign Data_In      = r_data_in;
   assign Issue_Valid  = r_issue_valid;
   assign Result_Valid = r_result_valid;
   assign Count        = r_count;
   assign Drop_Err     = r_drop_err;

endmodule
`default_nettype wire

// File: tb/tb_shift_cmd_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_cmd_queue
//  Purpose  : Directed self-checking bench for shift_cmd_queue (DEPTH = 4).
//             Each scenario task drives its stimulus and compares the DUT
//             outputs with hand-computed expected values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_cmd_queue;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          Clock;
   logic          Reset;
   logic          In_Valid;
   logic          In_Ready;
   logic          In_Direction;
   logic [2:0]    In_Shift_Amount;
   logic [7:0]    In_Data;
   logic          Out_Enable;
   logic          Direction;
   logic [2:0]    Shift_Amount;
   logic [7:0]    Data_In;
   logic          Issue_Valid;
   logic          Result_Valid;
   logic [CW-1:0] Count;
   logic          Drop_Err;

   int passed = 0;
   int total  = 0;

   shift_cmd_queue #(.DEPTH(DEPTH)) dut (
      .Clock           (Clock),
      .Reset           (Reset),
      .In_Valid        (In_Valid),
      .In_Ready        (In_Ready),
      .In_Direction    (In_Direction),
      .In_Shift_Amount (In_Shift_Amount),
      .In_Data         (In_Data),
      .Out_Enable      (Out_Enable),
      .Direction       (Direction),
      .Shift_Amount    (Shift_Amount),
      .Data_In         (Data_In),
      .Issue_Valid     (Issue_Valid),
      .Result_Valid    (Result_Valid),
      .Count           (Count),
      .Drop_Err        (Drop_Err)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   // Advance one rising edge; outputs are sampled 1 time unit later.
   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic d, input logic [2:0] a, input logic [7:0] x);
      In_Valid        = v;
      In_Direction    = d;
      In_Shift_Amount = a;
      In_Data         = x;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      drive(1'b0, 1'b0, 3'd0, 8'd0);
      Out_Enable = 1'b0;
      step();
      Reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      drive(1'b0, 1'b0, 3'd0, 8'd0);
      Out_Enable = 1'b0;
      #2;
      total++;
      if ({Count, Issue_Valid, Result_Valid, Drop_Err, In_Ready} !== {CW'(0), 4'b0000})
         $display("FAIL reset_state: got cnt=%0d iv=%b rv=%b de=%b rdy=%b, expected 0 0 0 0 0",
                  Count, Issue_Valid, Result_Valid, Drop_Err, In_Ready);
      else passed++;
      step();
      total++;
      if ({Direction, Shift_Amount, Data_In, In_Ready} !== 13'd0)
         $display("FAIL reset_outputs: got dir=%b amt=%0d data=%h rdy=%b, expected all 0",
                  Direction, Shift_Amount, Data_In, In_Ready);
      else passed++;
      Reset = 1'b0;
      #1;
      total++;
      if (In_Ready !== 1'b1 || Count !== CW'(0))
         $display("FAIL reset_release: got rdy=%b cnt=%0d, expected rdy=1 cnt=0", In_Ready, Count);
      else passed++;
   endtask

   task automatic test_single();
      Out_Enable = 1'b1;
      drive(1'b1, 1'b0, 3'd1, 8'h0F);
      step();                                   // accept edge
      drive(1'b0, 1'b0, 3'd0, 8'd0);
      total++;
      if (Issue_Valid !== 1'b0 || Count !== CW'(1))
         $display("FAIL single_no_bypass: got iv=%b cnt=%0d, expected iv=0 cnt=1", Issue_Valid, Count);
      else passed++;
      step();                                   // issue edge
      total++;
      if ({Issue_Valid, Direction, Shift_Amount, Data_In} !== {1'b1, 1'b0, 3'd1, 8'h0F} || Count !== CW'(0))
         $display("FAIL single_issue: got iv=%b dir=%b amt=%0d data=%h cnt=%0d, expected 1 0 1 0f 0",
                  Issue_Valid, Direction, Shift_Amount, Data_In, Count);
      else passed++;
      step();
      total++;
      if (Issue_Valid !== 1'b0 || Result_Valid !== 1'b1)
         $display("FAIL single_result: got iv=%b rv=%b, expected iv=0 rv=1", Issue_Valid, Result_Valid);
      else passed++;
      step();
      total++;
      if (Result_Valid !== 1'b0)
         $display("FAIL single_result_end: got rv=%b, expected 0", Result_Valid);
      else passed++;
   endtask

   task automatic test_fill_and_empty_pop();
      logic [11:0] exp;
      Out_Enable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, i[0], 3'(i + 1), 8'hA0 + 8'(i));
         step();
      end
      total++;
      if (Count !== CW'(4) || In_Ready !== 1'b0 || Drop_Err !== 1'b0)
         $display("FAIL fill_full: got cnt=%0d rdy=%b de=%b, expected cnt=4 rdy=0 de=0", Count, In_Ready, Drop_Err);
      else passed++;
      drive(1'b1, 1'b1, 3'd7, 8'hEE);           // offered while full
      step();
      drive(1'b0, 1'b0, 3'd0, 8'd0);
      total++;
      if (Count !== CW'(4) || Drop_Err !== 1'b1)
         $display("FAIL fill_drop: got cnt=%0d de=%b, expected cnt=4 de=1", Count, Drop_Err);
      else passed++;
      Out_Enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         exp = {i[0], 3'(i + 1), 8'hA0 + 8'(i)};
         total++;
         if (Issue_Valid !== 1'b1 || {Direction, Shift_Amount, Data_In} !== exp)
            $display("FAIL fill_pop_%0d: got iv=%b cmd=%h, expected iv=1 cmd=%h",
                     i, Issue_Valid, {Direction, Shift_Amount, Data_In}, exp);
         else passed++;
      end
      // Queue now empty with Out_Enable still high: outputs must hold A3 entry.
      for (int i = 0; i < 5; i++) begin
         step();
         total++;
         if (Issue_Valid !== 1'b0 || {Direction, Shift_Amount, Data_In} !== {1'b1, 3'd4, 8'hA3} || Count !== CW'(0))
            $display("FAIL empty_pop_%0d: got iv=%b cmd=%h cnt=%0d, expected iv=0 cmd=%h cnt=0",
                     i, Issue_Valid, {Direction, Shift_Amount, Data_In}, Count, {1'b1, 3'd4, 8'hA3});
         else passed++;
      end
      total++;
      if (Drop_Err !== 1'b1)
         $display("FAIL drop_sticky: got de=%b, expected 1", Drop_Err);
      else passed++;
   endtask

   task automatic test_wrap();
      int          idx;
      logic [7:0]  k;
      do_reset();
      idx = 0;
      Out_Enable = 1'b1;
      for (int cyc = 0; cyc < 15; cyc++) begin
         if (cyc < 10) begin
            k = 8'(cyc + 1);
            drive(1'b1, k[0], k[2:0], k);
         end else begin
            drive(1'b0, 1'b0, 3'd0, 8'd0);
         end
         step();
         if (Issue_Valid === 1'b1) begin
            k = 8'(idx + 1);
            total++;
            if ({Direction, Shift_Amount, Data_In} !== {k[0], k[2:0], k})
               $display("FAIL wrap_issue_%0d: got cmd=%h, expected cmd=%h",
                        idx, {Direction, Shift_Amount, Data_In}, {k[0], k[2:0], k});
            else passed++;
            idx++;
         end
      end
      total++;
      if (idx !== 10 || Drop_Err !== 1'b0 || Count !== CW'(0))
         $display("FAIL wrap_total: got issued=%0d de=%b cnt=%0d, expected 10 0 0", idx, Drop_Err, Count);
      else passed++;
   endtask

   task automatic test_back_to_back();
      do_reset();
      Out_Enable = 1'b0;
      drive(1'b1, 1'b1, 3'd2, 8'hB1); step();
      drive(1'b1, 1'b0, 3'd3, 8'hB2); step();
      drive(1'b1, 1'b1, 3'd5, 8'hB3);
      Out_Enable = 1'b1;
      step();                                   // push and pop together
      drive(1'b0, 1'b0, 3'd0, 8'd0);
      total++;
      if (Count !== CW'(2) || Issue_Valid !== 1'b1 || {Direction, Shift_Amount, Data_In} !== {1'b1, 3'd2, 8'hB1})
         $display("FAIL simul_push_pop: got cnt=%0d iv=%b cmd=%h, expected cnt=2 iv=1 cmd=%h",
                  Count, Issue_Valid, {Direction, Shift_Amount, Data_In}, {1'b1, 3'd2, 8'hB1});
      else passed++;
      step();
      total++;
      if (Count !== CW'(1) || {Direction, Shift_Amount, Data_In} !== {1'b0, 3'd3, 8'hB2})
         $display("FAIL simul_second: got cnt=%0d cmd=%h, expected cnt=1 cmd=%h",
                  Count, {Direction, Shift_Amount, Data_In}, {1'b0, 3'd3, 8'hB2});
      else passed++;
      step();
      total++;
      if (Count !== CW'(0) || {Direction, Shift_Amount, Data_In} !== {1'b1, 3'd5, 8'hB3})
         $display("FAIL simul_third: got cnt=%0d cmd=%h, expected cnt=0 cmd=%h",
                  Count, {Direction, Shift_Amount, Data_In}, {1'b1, 3'd5, 8'hB3});
      else passed++;
   endtask

   task automatic test_reset_mid();
      int stale;
      do_reset();
      Out_Enable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 3'd6, 8'hC0 + 8'(i));
         step();
      end
      drive(1'b0, 1'b0, 3'd0, 8'd0);
      Out_Enable = 1'b1;
      step();                                   // pop C0, Count = 3
      Out_Enable = 1'b0;
      step();                                   // Result_Valid in flight
      total++;
      if (Count !== CW'(3) || Result_Valid !== 1'b1)
         $display("FAIL mid_setup: got cnt=%0d rv=%b, expected cnt=3 rv=1", Count, Result_Valid);
      else passed++;
      #2;
      Reset = 1'b1;
      #1;
      total++;
      if ({Count, Direction, Shift_Amount, Data_In, Issue_Valid, Result_Valid, In_Ready} !== {CW'(0), 15'd0})
         $display("FAIL mid_reset_async: got cnt=%0d cmd=%h iv=%b rv=%b rdy=%b, expected all 0",
                  Count, {Direction, Shift_Amount, Data_In}, Issue_Valid, Result_Valid, In_Ready);
      else passed++;
      step();
      Reset = 1'b0;
      #1;
      total++;
      if (In_Ready !== 1'b1)
         $display("FAIL mid_release_ready: got rdy=%b, expected 1", In_Ready);
      else passed++;
      Out_Enable = 1'b1;
      stale = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (Issue_Valid !== 1'b0 || Result_Valid !== 1'b0) stale++;
      end
      total++;
      if (stale !== 0)
         $display("FAIL mid_no_stale: got %0d cycles with stale valid, expected 0", stale);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_and_empty_pop();
      test_wrap();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/shift_cmd_queue.md
SHIFT_CMD_QUEUE -- requirements
Module: shift_cmd_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, which sets the number of queued shift commands; legal values are 2, 4 and 8.
REQ-002 The block SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port In_Valid, input, 1 bit: the upstream command is present.
REQ-005 The block SHALL have port In_Ready, output, 1 bit: the queue can accept a command this cycle.
REQ-006 The block SHALL have port In_Direction, input, 1 bit: command direction, 0 = left, 1 = right.
REQ-007 The block SHALL have port In_Shift_Amount, input, 3 bits: command shift amount.
REQ-008 The block SHALL have port In_Data, input, 8 bits: command operand.
REQ-009 The block SHALL have port Out_Enable, input, 1 bit: the downstream shifter may take a command this cycle.
REQ-010 The block SHALL have port Direction, output, 1 bit, registered: drives the shifter Direction.
REQ-011 The block SHALL have port Shift_Amount, output, 3 bits, registered: drives the shifter Shift_Amount.
REQ-012 The block SHALL have port Data_In, output, 8 bits, registered: drives the shifter Data_In.
REQ-013 The block SHALL have port Issue_Valid, output, 1 bit, registered: Direction, Shift_Amount and Data_In carry a newly issued command.
REQ-014 The block SHALL have port Result_Valid, output, 1 bit, registered: the shifter Data_Out corresponds to the last issued command.
REQ-015 The block SHALL have port Count, output, clog2(DEPTH)+1 bits: the current occupancy.
REQ-016 The block SHALL have port Drop_Err, output, 1 bit, sticky: a command was offered while the queue was full.

Function
REQ-017 The queue SHALL be a FIFO of DEPTH entries of {direction, amount, data}, 12 bits wide, with read and write pointers that wrap modulo DEPTH.
REQ-018 In_Ready SHALL equal (Count < DEPTH) while Reset is low, and SHALL depend on registered state only, with no path from Out_Enable.
REQ-019 A push SHALL occur on a rising edge when In_Valid && In_Ready, writing the entry at the write pointer.
REQ-020 A pop SHALL occur on a rising edge when Out_Enable && Count > 0; the head entry is loaded into Direction, Shift_Amount and Data_In, and Issue_Valid = 1 for the following cycle.
REQ-021 When no pop occurs, Direction, Shift_Amount and Data_In SHALL hold their previous values and Issue_Valid SHALL be 0.
REQ-022 There SHALL be no bypass: a command pushed into an empty queue is popped at the earliest on the next edge, giving a minimum of 2 edges from accept to Issue_Valid.
REQ-023 On a simultaneous push and pop, Count SHALL be unchanged and both pointers SHALL advance.
REQ-024 Result_Valid SHALL equal Issue_Valid delayed by one cycle, matching the shifter's one-cycle registered latency.
REQ-025 Out_Enable while Count = 0 SHALL have no effect: no pop, and Issue_Valid = 0.
REQ-026 In_Valid while Count = DEPTH SHALL leave the command unaccepted and set Drop_Err = 1 on that edge; Drop_Err holds until Reset.
REQ-027 Commands SHALL issue in exact acceptance order, including across pointer wrap-around.

Reset
REQ-028 While Reset is high, the block SHALL asynchronously clear both pointers, Count, Direction, Shift_Amount, Data_In, Issue_Valid, Result_Valid and Drop_Err to 0, and SHALL drive In_Ready = 0.
REQ-029 Reset asserted mid-operation SHALL discard all queued commands and any in-flight Result_Valid.
REQ-030 On the first edge after Reset deasserts, the block SHALL behave as empty, with In_Ready = 1.

Verification
REQ-031 Single command: push {0, 3'd1, 8'h0F} with Out_Enable=1 -> Issue_Valid=1 for one cycle, 2 edges after accept, carrying Direction=0, Shift_Amount=1, Data_In=8'h0F; Result_Valid=1 on the next cycle.
REQ-032 Fill: Out_Enable=0, push 4 commands -> Count=4, In_Ready=0; a 5th In_Valid sets Drop_Err=1 and Count stays 4; with Out_Enable=1 the commands pop in order, one per cycle.
REQ-033 Wrap-around: stream 10 commands with Data 8'h01..8'h0A and Out_Enable=1 throughout -> issued Data is 01..0A in order, with no drops.
REQ-034 Simultaneous push/pop: at Count=2, push and pop on the same edge -> Count=2 and the head entry issues.
REQ-035 Reset mid-stream: with Count=3, assert Reset -> Count=0, outputs=0, In_Ready=0 and Result_Valid=0 immediately; after deassert, In_Ready=1 and no stale command ever issues.
REQ-036 Empty pop: Out_Enable=1 with Count=0 for 5 cycles -> Issue_Valid=0 and the output registers hold their previous values.
